// File: rtl/modulo_n_pkg.sv
// Purpose : shared mode encodings and default sizing for the modulo-N counter family.
// Latency : n/a (constants only).
// Backpressure: n/a.
package modulo_n_pkg;

   // Mode select {w1,w0}
   localparam logic [1:0] MODE_HOLD    = 2'b00;
   localparam logic [1:0] MODE_INC1    = 2'b01;
   localparam logic [1:0] MODE_INCSTEP = 2'b10;
   localparam logic [1:0] MODE_DEC1    = 2'b11;

   // Default sizing: drop-in replacement for the fixed modulo-10 counter
   localparam int DEF_MODULUS = 10;
   localparam int DEF_WIDTH   = 4;
   localparam int DEF_STEP    = 2;

endpackage

// File: rtl/modulo_n_next.sv
// Purpose : next-state logic for the modulo-N counter (load, hold, +1, +STEP, -1).
// Latency : purely combinational, zero cycles.
// Backpressure: none; a result is produced every cycle.
//
// Ports: state/mode/load/d in; next_state, next_wrap, next_loaderr out.
// Build option MODULO_N_SATURATE_EN: clamp at 0 / MODULUS-1 instead of wrapping;
// next_wrap then flags cycles where the clamp limited the result.
module modulo_n_next
   import modulo_n_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int STEP    = DEF_STEP
) (
   input  logic [WIDTH-1:0] state,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] next_state,
   output logic             next_wrap,
   output logic             next_loaderr
);

   // One extra bit so MODULUS == 2^WIDTH and state+STEP both fit without overflow
   localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   ONE_W  = (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MAX_S  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE_S  = WIDTH'(1);

   logic [WIDTH:0] k;
   logic [WIDTH:0] sum;

   always_comb begin
      k   = (mode == MODE_INCSTEP) ? STEP_W : ONE_W;
      sum = {1'b0, state} + k;
   end

   always_comb begin
      next_state   = state;
      next_wrap    = 1'b0;
      next_loaderr = 1'b0;

      if (load) begin
         // Out-of-range loads park at the top value and flag the error
         if ({1'b0, d} < MOD_W) begin
            next_state = d;
         end else begin
            next_state   = MAX_S;
            next_loaderr = 1'b1;
         end
      end else begin
         case (mode)
            MODE_INC1, MODE_INCSTEP: begin
               if (sum >= MOD_W) begin
`ifdef MODULO_N_SATURATE_EN
                  next_state = MAX_S;
`else
                  next_state = WIDTH'(sum - MOD_W);
`endif
                  next_wrap  = 1'b1;
               end else begin
                  next_state = sum[WIDTH-1:0];
               end
            end
            MODE_DEC1: begin
               if (state == '0) begin
`ifdef MODULO_N_SATURATE_EN
                  next_state = '0;
`else
                  next_state = MAX_S;
`endif
                  next_wrap  = 1'b1;
               end else begin
                  next_state = state - ONE_S;
               end
            end
            default: begin
               // MODE_HOLD: keep state, no wrap
            end
         endcase
      end
   end

endmodule

// File: rtl/modulo_n_counter.sv
// Purpose : parametrised modulo-N up/down counter with parallel load, wrap and load-error pulses.
// Latency : state/Wrap/LoadErr one rising edge after inputs; AtMax combinational from state.
// Backpressure: none; counts every cycle the mode is non-hold.
//
// Ports: Clock, Reset (async active-low), w1/w0 mode, Load/D parallel load;
//        state count bus, Wrap pulse, AtMax flag, LoadErr pulse.
// Build option MODULO_N_SATURATE_EN selects clamping instead of wrap-around.
module modulo_n_counter
   import modulo_n_pkg::*;
#(
   parameter int MODULUS = DEF_MODULUS,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int STEP    = DEF_STEP
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             w1,
   input  logic             w0,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] state,
   output logic             Wrap,
   output logic             AtMax,
   output logic             LoadErr
);

   if ((WIDTH < 1) || (WIDTH > 30)) begin : g_bad_width
      $error("modulo_n_counter: WIDTH out of range");
   end
   if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
      $error("modulo_n_counter: MODULUS must be in 2..2^WIDTH");
   end
   if ((STEP < 1) || (STEP > MODULUS - 1)) begin : g_bad_step
      $error("modulo_n_counter: STEP must be in 1..MODULUS-1");
   end

   localparam logic [WIDTH-1:0] MAX_S = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] next_state;
   logic             wrap_q;
   logic             next_wrap;
   logic             loaderr_q;
   logic             next_loaderr;

   modulo_n_next #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH),
      .STEP    (STEP)
   ) u_next (
      .state        (state_q),
      .mode         ({w1, w0}),
      .load         (Load),
      .d            (D),
      .next_state   (next_state),
      .next_wrap    (next_wrap),
      .next_loaderr (next_loaderr)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= '0;
         wrap_q    <= 1'b0;
         loaderr_q <= 1'b0;
      end else begin
         state_q   <= next_state;
         wrap_q    <= next_wrap;
         loaderr_q <= next_loaderr;
      end
   end

   assign state   = state_q;
   assign Wrap    = wrap_q;
   assign LoadErr = loaderr_q;
   assign AtMax   = (state_q == MAX_S);

endmodule

// File: tb/tb_modulo_n_counter.sv
module tb_modulo_n_counter;

   localparam int MOD  = 10;
   localparam int W    = 4;
   localparam int STEP = 2;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         w1, w0, Load;
   logic [W-1:0] D;
   logic [W-1:0] state;
   logic         Wrap, AtMax, LoadErr;

   int checks = 0;
   int errors = 0;

   // Reference model: plain integer arithmetic on the counter rules
   int m_state = 0;
   bit m_wrap  = 0;
   bit m_lerr  = 0;

   logic [W+2:0] act, exp;

   always #5 Clock = ~Clock;

   modulo_n_counter #(.MODULUS(MOD), .WIDTH(W), .STEP(STEP)) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .w1      (w1),
      .w0      (w0),
      .Load    (Load),
      .D       (D),
      .state   (state),
      .Wrap    (Wrap),
      .AtMax   (AtMax),
      .LoadErr (LoadErr)
   );

   task automatic model_next(input bit ld, input int d, input int mode);
      int t;
      m_wrap = 0;
      m_lerr = 0;
      if (ld) begin
         if (d < MOD) m_state = d;
         else begin
            m_state = MOD - 1;
            m_lerr  = 1;
         end
      end else if (mode != 0) begin
         if (mode == 3)      t = m_state - 1;
         else if (mode == 2) t = m_state + STEP;
         else                t = m_state + 1;
`ifdef MODULO_N_SATURATE_EN
         if (t >= MOD)    begin m_state = MOD - 1; m_wrap = 1; end
         else if (t < 0)  begin m_state = 0;       m_wrap = 1; end
         else m_state = t;
`else
         if (t >= MOD)    begin m_state = t - MOD; m_wrap = 1; end
         else if (t < 0)  begin m_state = t + MOD; m_wrap = 1; end
         else m_state = t;
`endif
      end
   endtask

   // One clocked cycle: drive inputs, take the edge, advance the model
   task automatic cyc(input bit ld, input int d, input int mode);
      Load = ld;
      D    = W'(d);
      {w1, w0} = 2'(mode);
      @(posedge Clock);
      #1;
      model_next(ld, d, mode);
   endtask

   task automatic sample();
      act = {state, Wrap, LoadErr, AtMax};
      exp = {W'(m_state), m_wrap, m_lerr, (m_state == MOD - 1)};
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      Load = 0; D = '0; {w1, w0} = 2'b01;
      repeat (3) @(posedge Clock);
      #1;
      m_state = 0; m_wrap = 0; m_lerr = 0;
      sample();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL reset_state: got %b expected %b (state,Wrap,LoadErr,AtMax)", act, exp);
      end
      Reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 1);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL count_up cycle %0d: got %b expected %b", i, act, exp);
         end
      end
   endtask

   task automatic test_count_down();
      cyc(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 3);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL count_down cycle %0d: got %b expected %b", i, act, exp);
         end
      end
   endtask

   task automatic test_step();
      cyc(1, 8, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 2);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL step_from8 cycle %0d: got %b expected %b", i, act, exp);
         end
      end
      cyc(1, 9, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 2);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL step_from9 cycle %0d: got %b expected %b", i, act, exp);
         end
      end
   endtask

   task automatic test_load();
      int dv[6] = '{5, 12, 9, 10, 15, 0};
      for (int i = 0; i < 6; i++) begin
         cyc(1, dv[i], 1);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL load D=%0d: got %b expected %b", dv[i], act, exp);
         end
         cyc(0, 0, 0);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL load_hold after D=%0d: got %b expected %b", dv[i], act, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      cyc(1, 4, 0);
      cyc(0, 0, 1);
      @(posedge Clock);
      #3;
      Reset = 1'b0;
      #1;
      m_state = 0; m_wrap = 0; m_lerr = 0;
      sample();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", act, exp);
      end
      #2;
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL hold_after_reset cycle %0d: got %b expected %b", i, act, exp);
         end
      end
   endtask

   task automatic test_random();
      bit ld;
      int d, mode;
      for (int i = 0; i < 400; i++) begin
         ld   = ($urandom_range(0, 7) == 0);
         d    = $urandom_range(0, 15);
         mode = $urandom_range(0, 3);
         cyc(ld, d, mode);
         sample();
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL random cycle %0d ld=%0d d=%0d mode=%0d: got %b expected %b",
                     i, ld, d, mode, act, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_down();
      test_step();
      test_load();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/modulo_n_counter.md
# modulo_n_counter

Parametrised modulo-N up/down counter FSM, successor to the fixed modulo-10 counter. The count modulus, state width and large-step size are parameters. It adds a synchronous parallel load, a registered wrap pulse and a load-error flag. It sits under the same mode-select inputs (w1, w0) used by the existing counter FSMs and drives a binary state bus to downstream display/sequencing logic.

## Interface
- MODULUS, default 10: number of states, legal range 2..2^WIDTH.
- WIDTH, default 4: state bus width; must satisfy 2^WIDTH >= MODULUS.
- STEP, default 2: increment applied in mode 10; legal range 1..MODULUS-1.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- w1  input  1  mode select, high bit.
- w0  input  1  mode select, low bit.
- Load  input  1  synchronous parallel load; overrides mode.
- D  input  WIDTH  load value.
- state  output  WIDTH  current count, always in 0..MODULUS-1.
- Wrap  output  1  registered one-cycle pulse on modulo wrap (or saturation hit, see Configuration).
- AtMax  output  1  combinational, state == MODULUS-1.
- LoadErr  output  1  registered one-cycle pulse: last load value was out of range.

## Operation
- Mode {w1,w0}:
  - 00: hold.
  - 01: +1.
  - 10: +STEP.
  - 11: -1.
- Priority: Reset > Load > mode.
- Increment: next = (state + k) mod MODULUS.
  - Compute in WIDTH+1 bits; subtract MODULUS if sum >= MODULUS.
  - k is 1 or STEP.
- Decrement: state 0 -> MODULUS-1; otherwise state-1.
- Wrap = 1 in the cycle after a transition that crossed the boundary:
  - increment where sum >= MODULUS;
  - decrement from 0.
- Hold never asserts Wrap.
- Load:
  - D < MODULUS: state <= D.
  - D >= MODULUS: state <= MODULUS-1 and LoadErr pulses.
  - Load never asserts Wrap.
- Load and mode asserted together: Load wins; the mode is ignored for that cycle.
- Reset deasserted mid-sequence: counting resumes from 0 on the first rising edge after release.

## Timing
- Reset values: state = 0, Wrap = 0, LoadErr = 0; AtMax = 0 (MODULUS >= 2).
- Reset assertion clears all registers immediately, independent of Clock.
- Latency:
  - state, Wrap and LoadErr change one rising edge after the sampled inputs.
  - AtMax follows state combinationally with zero cycles of latency.
- Wrap and LoadErr are high for exactly one cycle per event. Consecutive wrapping cycles give consecutive high cycles.
- Inputs are sampled only at the rising edge. There is no handshake; the count advances every cycle the mode is non-00.

## Configuration
- MODULO_N_SATURATE_EN defined:
  - Increments clamp at MODULUS-1 and decrements clamp at 0; no wrap-around.
  - Wrap pulses on the cycle a clamp actually limited the result, e.g. MODULUS-2 +STEP(2) -> MODULUS-1.
  - Holding at the clamp with the same mode keeps Wrap pulsing each cycle.
- Not defined: modulo wrap-around as described in Operation.
- Load and LoadErr behave identically in both builds.

## Structure
- Shared package modulo_n_pkg holds:
  - mode encoding constants: MODE_HOLD = 2'b00, MODE_INC1 = 2'b01, MODE_INCSTEP = 2'b10, MODE_DEC1 = 2'b11;
  - the default MODULUS/WIDTH/STEP constants.
- One combinational sub-module, modulo_n_next. It takes state, mode and D/Load, and returns next state, wrap and load-error. The MODULO_N_SATURATE_EN ifdef lives only here.
- The top level contains only the registers and the AtMax compare.
- Elaboration-time checks reject parameters outside their legal ranges.

## Test plan
All scenarios use MODULUS=10, WIDTH=4, STEP=2 unless stated.
- Reset low, w1w0=01 -> state=0; after release, 12 edges give 1..9, 0, 1, 2, with Wrap high only on the 9->0 cycle.
- state=0, w1w0=11 -> 9, 8, 7; Wrap pulses on the 0->9 cycle.
- state=8, w1w0=10 -> 0 (Wrap=1), then 2, 4, 6, 8, 0; from state=9 -> 1 with Wrap=1.
- Load=1, D=5 with w1w0=01 -> state=5, Wrap=0; Load=1, D=12 -> state=9, LoadErr=1 for one cycle, AtMax=1.
- Reset asserted asynchronously between edges while counting -> state=0 immediately; w1w0=00 afterwards holds 0.
- Build with MODULO_N_SATURATE_EN, state=8, w1w0=01 -> 9 then 9 (Wrap=1 each clamped cycle); w1w0=11 from 0 -> stays 0 with Wrap=1.
